// File: rtl/execute_stage.sv
// Execute stage: captures decode fields with write-back bypass, forwards operands,
// evaluates ALU/jump results and hosts the byte-lane data memory.
module execute_stage #(
  parameter int unsigned DM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc_in,
  input  logic [5:0]  op_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [10:0] aux_in,
  input  logic [31:0] imm_dpl_in,
  input  logic [25:0] addr_in,
  input  logic [31:0] os_in,
  input  logic [31:0] ot_in,
  input  logic [4:0]  wreg_w,
  input  logic [31:0] w_data_w,
  output logic [31:0] pc_e,
  output logic [5:0]  op_e,
  output logic [25:0] addr_e,
  output logic [31:0] imm_dpl_e,
  output logic [31:0] os_e,
  output logic [31:0] ot_e,
  output logic [4:0]  wreg_e,
  output logic [31:0] alu_result_e,
  output logic [31:0] dm_addr_e,
  output logic [3:0]  wren_e
);

  localparam int unsigned IdxW = $clog2(DM_DEPTH);

  localparam logic [5:0] OpRType = 6'd0;
  localparam logic [5:0] OpAddi  = 6'd1;
  localparam logic [5:0] OpLui   = 6'd3;
  localparam logic [5:0] OpAndi  = 6'd4;
  localparam logic [5:0] OpOri   = 6'd5;
  localparam logic [5:0] OpXori  = 6'd6;
  localparam logic [5:0] OpLw    = 6'd16;
  localparam logic [5:0] OpLh    = 6'd18;
  localparam logic [5:0] OpLb    = 6'd20;
  localparam logic [5:0] OpSw    = 6'd24;
  localparam logic [5:0] OpSh    = 6'd26;
  localparam logic [5:0] OpSb    = 6'd28;
  localparam logic [5:0] OpJal   = 6'd41;

  localparam logic [5:0] FnAdd = 6'd0;
  localparam logic [5:0] FnSub = 6'd2;
  localparam logic [5:0] FnAnd = 6'd8;
  localparam logic [5:0] FnOr  = 6'd9;
  localparam logic [5:0] FnXor = 6'd10;
  localparam logic [5:0] FnNor = 6'd11;
  localparam logic [5:0] FnSll = 6'd16;
  localparam logic [5:0] FnSrl = 6'd17;
  localparam logic [5:0] FnSra = 6'd18;

  logic [31:0] pc_q, imm_q, os_q, ot_q;
  logic [31:0] os_d, ot_d;
  logic [5:0]  op_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [10:0] aux_q;
  logic [25:0] addr_q;

  // Write-back result landing in the same cycle as capture overrides stale register reads
  always_comb begin
    os_d = os_in;
    ot_d = ot_in;
    if (wreg_w != 5'd0 && rs_in == wreg_w) os_d = w_data_w;
    if (wreg_w != 5'd0 && rt_in == wreg_w) ot_d = w_data_w;
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      pc_q   <= '0;
      op_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      aux_q  <= '0;
      imm_q  <= '0;
      addr_q <= '0;
      os_q   <= '0;
      ot_q   <= '0;
    end else begin
      pc_q   <= pc_in;
      op_q   <= op_in;
      rs_q   <= rs_in;
      rt_q   <= rt_in;
      rd_q   <= rd_in;
      aux_q  <= aux_in;
      imm_q  <= imm_dpl_in;
      addr_q <= addr_in;
      os_q   <= os_d;
      ot_q   <= ot_d;
    end
  end

  assign pc_e      = pc_q;
  assign op_e      = op_q;
  assign addr_e    = addr_q;
  assign imm_dpl_e = imm_q;
  assign os_e      = (wreg_w != 5'd0 && rs_q == wreg_w) ? w_data_w : os_q;
  assign ot_e      = (wreg_w != 5'd0 && rt_q == wreg_w) ? w_data_w : ot_q;
  assign dm_addr_e = os_e + imm_q;

  // Data memory is deliberately outside the reset domain
  logic [3:0][7:0] dmem_q [DM_DEPTH] = '{default: '0};
  logic [IdxW-1:0] dm_idx;
  logic [31:0]     rd_word;

  assign dm_idx  = dm_addr_e[IdxW-1:0];
  assign rd_word = dmem_q[dm_idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wren_e[i]) dmem_q[dm_idx][i] <= alu_result_e[8*i +: 8];
    end
  end

  logic [4:0]  shamt;
  logic [31:0] imm_zx;

  assign shamt  = aux_q[10:6];
  assign imm_zx = {16'b0, imm_q[15:0]};

  always_comb begin
    alu_result_e = '0;
    wreg_e       = '0;
    wren_e       = '0;
    case (op_q)
      OpRType: begin
        wreg_e = rd_q;
        case (aux_q[5:0])
          FnAdd:   alu_result_e = os_e + ot_e;
          FnSub:   alu_result_e = os_e - ot_e;
          FnAnd:   alu_result_e = os_e & ot_e;
          FnOr:    alu_result_e = os_e | ot_e;
          FnXor:   alu_result_e = os_e ^ ot_e;
          FnNor:   alu_result_e = ~(os_e | ot_e);
          FnSll:   alu_result_e = os_e << shamt;
          FnSrl:   alu_result_e = os_e >> shamt;
          FnSra:   alu_result_e = $unsigned($signed(os_e) >>> shamt);
          default: wreg_e = '0;
        endcase
      end
      OpAddi: begin
        wreg_e       = rt_q;
        alu_result_e = os_e + imm_q;
      end
      OpLui: begin
        wreg_e       = rt_q;
        alu_result_e = {imm_q[15:0], 16'b0};
      end
      OpAndi: begin
        wreg_e       = rt_q;
        alu_result_e = os_e & imm_zx;
      end
      OpOri: begin
        wreg_e       = rt_q;
        alu_result_e = os_e | imm_zx;
      end
      OpXori: begin
        wreg_e       = rt_q;
        alu_result_e = os_e ^ imm_zx;
      end
      OpLw: begin
        wreg_e       = rt_q;
        alu_result_e = rd_word;
      end
      OpLh: begin
        wreg_e       = rt_q;
        alu_result_e = {{16{rd_word[15]}}, rd_word[15:0]};
      end
      OpLb: begin
        wreg_e       = rt_q;
        alu_result_e = {{24{rd_word[7]}}, rd_word[7:0]};
      end
      OpSw: begin
        alu_result_e = ot_e;
        wren_e       = 4'b1111;
      end
      OpSh: begin
        alu_result_e = ot_e;
        wren_e       = 4'b0011;
      end
      OpSb: begin
        alu_result_e = ot_e;
        wren_e       = 4'b0001;
      end
      OpJal: begin
        wreg_e       = 5'd31;
        alu_result_e = pc_q + 32'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, multi-cycle corner sequences and
// randomized traffic against a behavioural model of the stage and its data memory.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] pc_in, imm_dpl_in, os_in, ot_in, w_data_w;
  logic [5:0]  op_in;
  logic [4:0]  rs_in, rt_in, rd_in, wreg_w;
  logic [10:0] aux_in;
  logic [25:0] addr_in;
  logic [31:0] pc_e, imm_dpl_e, os_e, ot_e, alu_result_e, dm_addr_e;
  logic [5:0]  op_e;
  logic [25:0] addr_e;
  logic [4:0]  wreg_e;
  logic [3:0]  wren_e;

  execute_stage #(.DM_DEPTH(256)) dut (
    .clk(clk), .rstd(rstd), .pc_in(pc_in), .op_in(op_in), .rs_in(rs_in), .rt_in(rt_in),
    .rd_in(rd_in), .aux_in(aux_in), .imm_dpl_in(imm_dpl_in), .addr_in(addr_in),
    .os_in(os_in), .ot_in(ot_in), .wreg_w(wreg_w), .w_data_w(w_data_w), .pc_e(pc_e),
    .op_e(op_e), .addr_e(addr_e), .imm_dpl_e(imm_dpl_e), .os_e(os_e), .ot_e(ot_e),
    .wreg_e(wreg_e), .alu_result_e(alu_result_e), .dm_addr_e(dm_addr_e), .wren_e(wren_e)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [10:0] aux;
    logic [31:0] imm;
    logic [25:0] addr;
    logic [31:0] os, ot;
  } e_t;

  logic [31:0] mem_w [256];

  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] v,
                                       input logic [4:0] ww, input logic [31:0] wd);
    return (ww != 0 && r == ww) ? wd : v;
  endfunction

  task automatic model_exec(input e_t e, input logic [4:0] ww, input logic [31:0] wd,
                            output logic [4:0] xw, output logic [31:0] xr,
                            output logic [3:0] xwe, output logic [31:0] xa,
                            output logic [31:0] xos, output logic [31:0] xot);
    logic [31:0] word;
    int sh;
    xos = pick(e.rs, e.os, ww, wd);
    xot = pick(e.rt, e.ot, ww, wd);
    xa = xos + e.imm;
    word = mem_w[xa % 256];
    sh = int'(e.aux[10:6]);
    xw = 0; xr = 0; xwe = 0;
    case (int'(e.op))
      0: begin
        xw = e.rd;
        case (int'(e.aux[5:0]))
          0: xr = xos + xot;
          2: xr = xos - xot;
          8: xr = xos & xot;
          9: xr = xos | xot;
          10: xr = xos ^ xot;
          11: xr = ~(xos | xot);
          16: xr = xos << sh;
          17: xr = xos >> sh;
          18: xr = $unsigned($signed(xos) >>> sh);
          default: xw = 0;
        endcase
      end
      1: begin xw = e.rt; xr = xos + e.imm; end
      3: begin xw = e.rt; xr = e.imm[15:0] * 32'h10000; end
      4: begin xw = e.rt; xr = xos & (e.imm % 32'h10000); end
      5: begin xw = e.rt; xr = xos | (e.imm % 32'h10000); end
      6: begin xw = e.rt; xr = xos ^ (e.imm % 32'h10000); end
      16: begin xw = e.rt; xr = word; end
      18: begin xw = e.rt; xr = {{16{word[15]}}, word[15:0]}; end
      20: begin xw = e.rt; xr = {{24{word[7]}}, word[7:0]}; end
      24: begin xr = xot; xwe = 4'b1111; end
      26: begin xr = xot; xwe = 4'b0011; end
      28: begin xr = xot; xwe = 4'b0001; end
      41: begin xw = 5'd31; xr = e.pc + 1; end
      default: ;
    endcase
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt, rd;
    logic [10:0] aux;
    logic [31:0] imm, os, ot, pc;
    logic [4:0]  x_wreg;
    logic [31:0] x_res;
    logic [3:0]  x_wren;
    logic [31:0] x_addr;
  } vec_t;

  vec_t vecs [19];

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [10:0] aux, input logic [31:0] imm,
                       input logic [31:0] os, input logic [31:0] ot, input logic [31:0] pc);
    op_in = op; rs_in = rs; rt_in = rt; rd_in = rd; aux_in = aux; imm_dpl_in = imm;
    os_in = os; ot_in = ot; pc_in = pc; addr_in = 26'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] op_pool [16];
  logic [5:0] fn_pool [10];

  initial begin
    e_t          me, mn;
    logic [4:0]  xw;
    logic [31:0] xr, xa, xos, xot, r;
    logic [3:0]  xwe;

    vecs[0]  = '{6'd1,  5'd9, 5'd0, 11'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 5'd9, 32'd2, 4'd0, 32'd2};
    vecs[1]  = '{6'd0,  5'd1, 5'd4, 11'd0, 32'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd4, 32'h80000000, 4'd0, 32'h7FFFFFFF};
    vecs[2]  = '{6'd0,  5'd1, 5'd3, 11'd2, 32'd0, 32'd3, 32'd5, 32'd0, 5'd3, 32'hFFFFFFFE, 4'd0, 32'd3};
    vecs[3]  = '{6'd0,  5'd1, 5'd5, 11'd8, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd5, 32'hF000F000, 4'd0, 32'hF0F0F0F0};
    vecs[4]  = '{6'd0,  5'd1, 5'd5, 11'd9, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd5, 32'hFFF0FFF0, 4'd0, 32'hF0F0F0F0};
    vecs[5]  = '{6'd0,  5'd1, 5'd5, 11'd10, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd5, 32'h0FF00FF0, 4'd0, 32'hF0F0F0F0};
    vecs[6]  = '{6'd0,  5'd1, 5'd5, 11'd11, 32'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd5, 32'h000F000F, 4'd0, 32'hF0F0F0F0};
    vecs[7]  = '{6'd0,  5'd1, 5'd6, {5'd4, 6'd16}, 32'd0, 32'h80000001, 32'd0, 32'd0, 5'd6, 32'h00000010, 4'd0, 32'h80000001};
    vecs[8]  = '{6'd0,  5'd1, 5'd6, {5'd4, 6'd17}, 32'd0, 32'h80000001, 32'd0, 32'd0, 5'd6, 32'h08000000, 4'd0, 32'h80000001};
    vecs[9]  = '{6'd0,  5'd1, 5'd6, {5'd4, 6'd18}, 32'd0, 32'h80000001, 32'd0, 32'd0, 5'd6, 32'hF8000000, 4'd0, 32'h80000001};
    vecs[10] = '{6'd0,  5'd1, 5'd6, 11'd3, 32'd0, 32'd1, 32'd2, 32'd0, 5'd0, 32'd0, 4'd0, 32'd1};
    vecs[11] = '{6'd3,  5'd2, 5'd0, 11'd0, 32'hFFFF1234, 32'd0, 32'd0, 32'd0, 5'd2, 32'h12340000, 4'd0, 32'hFFFF1234};
    vecs[12] = '{6'd4,  5'd3, 5'd0, 11'd0, 32'hFFFF8765, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd3, 32'h00008765, 4'd0, 32'hFFFF8764};
    vecs[13] = '{6'd5,  5'd3, 5'd0, 11'd0, 32'hFFFF00FF, 32'h12340000, 32'd0, 32'd0, 5'd3, 32'h123400FF, 4'd0, 32'h123300FF};
    vecs[14] = '{6'd6,  5'd3, 5'd0, 11'd0, 32'h0000F0F0, 32'h0000FFFF, 32'd0, 32'd0, 5'd3, 32'h00000F0F, 4'd0, 32'h0001F0EF};
    vecs[15] = '{6'd41, 5'd3, 5'd7, 11'd0, 32'd0, 32'd0, 32'd0, 32'h40, 5'd31, 32'h41, 4'd0, 32'd0};
    vecs[16] = '{6'd32, 5'd3, 5'd5, 11'd0, 32'd0, 32'd1, 32'd1, 32'h40, 5'd0, 32'd0, 4'd0, 32'd1};
    vecs[17] = '{6'd63, 5'd3, 5'd5, 11'd0, 32'd0, 32'd0, 32'd0, 32'h40, 5'd0, 32'd0, 4'd0, 32'd0};
    vecs[18] = '{6'd7,  5'd3, 5'd5, 11'd0, 32'd8, 32'd1, 32'd0, 32'h40, 5'd0, 32'd0, 4'd0, 32'd9};

    op_pool = '{6'd0, 6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd16, 6'd18, 6'd20,
                6'd24, 6'd26, 6'd28, 6'd41, 6'd32, 6'd63};
    fn_pool = '{6'd0, 6'd2, 6'd8, 6'd9, 6'd10, 6'd11, 6'd16, 6'd17, 6'd18, 6'd5};
    for (int i = 0; i < 256; i++) mem_w[i] = '0;

    // ---- reset ----
    rstd = 1'b1; wreg_w = 0; w_data_w = 0;
    drive(6'd1, 5'd3, 5'd4, 5'd5, 11'd0, 32'd7, 32'd9, 32'd11, 32'h10);
    tick(); tick();
    check("reset wreg_e", {27'd0, wreg_e}, 32'd0);
    check("reset wren_e", {28'd0, wren_e}, 32'd0);
    check("reset alu_result_e", alu_result_e, 32'd0);
    check("reset dm_addr_e", dm_addr_e, 32'd0);
    check("reset os_e", os_e, 32'd0);
    check("reset op_e", {26'd0, op_e}, 32'd0);
    drive(6'd0, 5'd0, 5'd0, 5'd0, 11'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rstd = 1'b0;
    tick();

    // ---- randomized traffic vs. model ----
    me = '0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom;
      op_in = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 15)];
      rs_in = 5'($urandom_range(0, 7));
      rt_in = 5'($urandom_range(0, 7));
      rd_in = 5'($urandom_range(0, 31));
      aux_in = {5'($urandom), fn_pool[$urandom_range(0, 9)]};
      imm_dpl_in = {{16{r[15]}}, r[15:0]};
      os_in = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      ot_in = $urandom;
      pc_in = $urandom;
      addr_in = 26'($urandom);
      wreg_w = 5'($urandom_range(0, 7));
      w_data_w = $urandom_range(0, 400);
      @(negedge clk);
      model_exec(me, wreg_w, w_data_w, xw, xr, xwe, xa, xos, xot);
      check($sformatf("rnd%0d wreg_e", it), {27'd0, wreg_e}, {27'd0, xw});
      check($sformatf("rnd%0d alu_result_e", it), alu_result_e, xr);
      check($sformatf("rnd%0d wren_e", it), {28'd0, wren_e}, {28'd0, xwe});
      check($sformatf("rnd%0d dm_addr_e", it), dm_addr_e, xa);
      check($sformatf("rnd%0d os_e", it), os_e, xos);
      check($sformatf("rnd%0d ot_e", it), ot_e, xot);
      check($sformatf("rnd%0d pc_e", it), pc_e, me.pc);
      check($sformatf("rnd%0d op_e", it), {26'd0, op_e}, {26'd0, me.op});
      check($sformatf("rnd%0d imm_dpl_e", it), imm_dpl_e, me.imm);
      check($sformatf("rnd%0d addr_e", it), {6'd0, addr_e}, {6'd0, me.addr});
      for (int l = 0; l < 4; l++) if (xwe[l]) mem_w[xa % 256][8*l +: 8] = xr[8*l +: 8];
      mn = '{pc_in, op_in, rs_in, rt_in, rd_in, aux_in, imm_dpl_in, addr_in,
             pick(rs_in, os_in, wreg_w, w_data_w), pick(rt_in, ot_in, wreg_w, w_data_w)};
      tick();
      me = mn;
    end

    // ---- directed table ----
    wreg_w = 0; w_data_w = 0;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].op, 5'd1, vecs[i].rt, vecs[i].rd, vecs[i].aux, vecs[i].imm,
            vecs[i].os, vecs[i].ot, vecs[i].pc);
      tick();
      check($sformatf("vec%0d wreg_e", i), {27'd0, wreg_e}, {27'd0, vecs[i].x_wreg});
      check($sformatf("vec%0d alu_result_e", i), alu_result_e, vecs[i].x_res);
      check($sformatf("vec%0d wren_e", i), {28'd0, wren_e}, {28'd0, vecs[i].x_wren});
      check($sformatf("vec%0d dm_addr_e", i), dm_addr_e, vecs[i].x_addr);
    end

    // ---- store then load, 8-bit index wrap ----
    drive(6'd24, 5'd1, 5'd2, 5'd0, 11'd0, 32'd4, 32'h100, 32'h315, 32'd0);
    tick();
    check("sw wren_e", {28'd0, wren_e}, 32'hF);
    check("sw alu_result_e", alu_result_e, 32'h315);
    check("sw wreg_e", {27'd0, wreg_e}, 32'd0);
    drive(6'd16, 5'd1, 5'd6, 5'd0, 11'd0, 32'd4, 32'h100, 32'd0, 32'd0);
    tick();
    check("lw after sw", alu_result_e, 32'h315);
    check("lw wreg_e", {27'd0, wreg_e}, 32'd6);
    drive(6'd16, 5'd1, 5'd6, 5'd0, 11'd0, 32'd4, 32'h0, 32'd0, 32'd0);
    tick();
    check("lw wrapped index", alu_result_e, 32'h315);

    // ---- byte / half lanes ----
    drive(6'd24, 5'd1, 5'd2, 5'd0, 11'd0, 32'd10, 32'd0, 32'h11223344, 32'd0);
    tick();
    drive(6'd28, 5'd1, 5'd2, 5'd0, 11'd0, 32'd10, 32'd0, 32'hABCDEFFF, 32'd0);
    tick();
    check("sb wren_e", {28'd0, wren_e}, 32'h1);
    drive(6'd20, 5'd1, 5'd6, 5'd0, 11'd0, 32'd10, 32'd0, 32'd0, 32'd0);
    tick();
    check("lb sign-ext", alu_result_e, 32'hFFFFFFFF);
    drive(6'd18, 5'd1, 5'd6, 5'd0, 11'd0, 32'd10, 32'd0, 32'd0, 32'd0);
    tick();
    check("lh", alu_result_e, 32'h000033FF);
    drive(6'd16, 5'd1, 5'd6, 5'd0, 11'd0, 32'd10, 32'd0, 32'd0, 32'd0);
    tick();
    check("lw after sb", alu_result_e, 32'h112233FF);

    // ---- execute forwarding and capture bypass ----
    drive(6'd1, 5'd7, 5'd1, 5'd0, 11'd0, 32'd0, 32'd100, 32'd3, 32'd0);
    tick();
    wreg_w = 5'd7; w_data_w = 32'd55; #1;
    check("fwd os_e", os_e, 32'd55);
    check("fwd alu_result_e", alu_result_e, 32'd55);
    wreg_w = 5'd0; #1;
    check("nofwd os_e", os_e, 32'd100);
    wreg_w = 5'd1; w_data_w = 32'd9; #1;
    check("fwd ot_e", ot_e, 32'd9);
    drive(6'd1, 5'd7, 5'd2, 5'd0, 11'd0, 32'd0, 32'd1, 32'd3, 32'd0);
    wreg_w = 5'd7; w_data_w = 32'd77;
    tick();
    wreg_w = 5'd0; #1;
    check("capture bypass os_e", os_e, 32'd77);

    // ---- reset pulse kills an in-flight store, memory retained ----
    drive(6'd24, 5'd1, 5'd2, 5'd0, 11'd0, 32'd20, 32'd0, 32'hA5A5A5A5, 32'd0);
    tick();
    drive(6'd24, 5'd1, 5'd2, 5'd0, 11'd0, 32'd20, 32'd0, 32'h5A5A5A5A, 32'd0);
    tick();
    check("sw2 wren_e", {28'd0, wren_e}, 32'hF);
    #2 rstd = 1'b1;
    #1;
    check("midreset wren_e", {28'd0, wren_e}, 32'd0);
    check("midreset wreg_e", {27'd0, wreg_e}, 32'd0);
    check("midreset alu_result_e", alu_result_e, 32'd0);
    drive(6'd16, 5'd1, 5'd8, 5'd0, 11'd0, 32'd20, 32'd0, 32'd0, 32'd0);
    #1 rstd = 1'b0;
    tick();
    check("post-reset lw wreg_e", {27'd0, wreg_e}, 32'd8);
    check("post-reset lw data", alu_result_e, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
